// File: rtl/dit_fft_ctrl_pkg.sv
// Shared constants, state encoding and butterfly request payload for the 16-point DIT FFT sequencer.
package dit_pkg;

    localparam int unsigned VLEN           = 16;
    localparam int unsigned VLEN_LOG2      = 4;
    localparam int unsigned BFLY_PER_STAGE = VLEN / 2;
    localparam int unsigned SEL_W          = VLEN_LOG2 + 1;
    localparam int unsigned TW_W           = VLEN_LOG2 - 1;
    localparam int unsigned STG_W          = VLEN_LOG2 / 2;
    localparam int unsigned PERF_W         = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_LAST,
        BFLY_REQ,
        BFLY_WAIT,
        DONE
    } dit_ctrl_state_t;

    typedef struct packed {
        logic [VLEN_LOG2-1:0] top;
        logic [VLEN_LOG2-1:0] bot;
        logic [TW_W-1:0]      tw;
    } bf_req_t;

endpackage

// File: rtl/dit_fft_ctrl_if.sv
// Handshake bundle between the FFT sequencer, sample store, working RAM and butterfly unit.
interface dit_fft_ctrl_if;
    import dit_pkg::*;

    logic                 start;
    logic                 store_full;
    logic                 store_get;
    logic [SEL_W-1:0]     store_choose;
    logic                 store_release;
    logic                 ram_we;
    logic [VLEN_LOG2-1:0] ram_waddr;
    logic                 bf_valid;
    logic                 bf_ready;
    logic [VLEN_LOG2-1:0] bf_top;
    logic [VLEN_LOG2-1:0] bf_bot;
    logic [TW_W-1:0]      bf_tw;
    logic                 bf_done;
    logic [STG_W-1:0]     stage;
    logic                 busy;
    logic                 fft_done;

    modport master (
        input  start, store_full, bf_ready, bf_done,
        output store_get, store_choose, store_release, ram_we, ram_waddr,
               bf_valid, bf_top, bf_bot, bf_tw, stage, busy, fft_done
    );

    modport slave (
        output start, store_full, bf_ready, bf_done,
        input  store_get, store_choose, store_release, ram_we, ram_waddr,
               bf_valid, bf_top, bf_bot, bf_tw, stage, busy, fft_done
    );

endinterface

// File: rtl/dit_fft_ctrl_addr_gen.sv
// Combinational butterfly index generator: (stage s, butterfly j) -> top/bottom operand and twiddle index.
module dit_addr_gen
    import dit_pkg::*;
(
    input  logic [STG_W-1:0] s,
    input  logic [TW_W-1:0]  j,
    output bf_req_t          req_c
);

    logic [VLEN_LOG2-1:0] j_w;
    logic [VLEN_LOG2-1:0] half;
    logic [VLEN_LOG2-1:0] lo;

    // Group base is (j / half) * 2*half; lo is the offset inside the group.
    always_comb begin
        j_w       = VLEN_LOG2'(j);
        half      = VLEN_LOG2'(1) << s;
        lo        = j_w & (half - VLEN_LOG2'(1));
        req_c.top = ((j_w >> s) << (32'(s) + 32'd1)) | lo;
        req_c.bot = req_c.top + half;
        req_c.tw  = TW_W'(lo << (32'(TW_W) - 32'(s)));
    end

endmodule

// File: rtl/dit_fft_ctrl.sv
// Sequencer for the 16-point radix-2 DIT FFT: frame load, then 4x8 butterflies on a shared unit.
// Optional perf_cycles counter enabled by defining DIT_CTRL_PERF_EN.
module dit_fft_ctrl
    import dit_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    dit_fft_ctrl_if.master io
`ifdef DIT_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycles
`endif
);

    localparam logic [VLEN_LOG2-1:0] LAST_CNT = VLEN_LOG2'(VLEN - 1);
    localparam logic [TW_W-1:0]      LAST_J   = TW_W'(BFLY_PER_STAGE - 1);
    localparam logic [STG_W-1:0]     LAST_S   = STG_W'(VLEN_LOG2 - 1);

    dit_ctrl_state_t      state_q, state_d;
    logic [VLEN_LOG2-1:0] cnt_q, cnt_d;
    logic [TW_W-1:0]      j_q, j_d;
    logic [STG_W-1:0]     s_q, s_d;

    logic                 store_get_q, store_get_d;
    logic [SEL_W-1:0]     store_choose_q, store_choose_d;
    logic                 store_release_q, store_release_d;
    logic                 ram_we_q, ram_we_d;
    logic [VLEN_LOG2-1:0] ram_waddr_q, ram_waddr_d;
    logic                 bf_valid_q, bf_valid_d;
    bf_req_t              bf_req_q, bf_req_d;
    logic [STG_W-1:0]     stage_q, stage_d;
    logic                 busy_q, busy_d;
    logic                 fft_done_q, fft_done_d;

    bf_req_t              addr_c;

    dit_addr_gen u_addr_gen (
        .s     (s_d),
        .j     (j_d),
        .req_c (addr_c)
    );

    // Next state and counters; registered outputs are decoded from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        s_d     = s_q;

        unique case (state_q)
            IDLE: begin
                if (io.start && io.store_full) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    j_d     = '0;
                    s_d     = '0;
                end
            end
            LOAD: begin
                cnt_d = cnt_q + VLEN_LOG2'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = LOAD_LAST;
                end
            end
            LOAD_LAST: begin
                j_d     = '0;
                s_d     = '0;
                state_d = BFLY_REQ;
            end
            BFLY_REQ: begin
                if (io.bf_ready) begin
                    state_d = BFLY_WAIT;
                end
            end
            BFLY_WAIT: begin
                if (io.bf_done) begin
                    if (j_q == LAST_J && s_q == LAST_S) begin
                        state_d = DONE;
                    end else begin
                        j_d     = j_q + TW_W'(1);
                        state_d = BFLY_REQ;
                        if (j_q == LAST_J) begin
                            s_d = s_q + STG_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        store_get_d     = (state_d == LOAD);
        store_choose_d  = store_get_d ? SEL_W'(cnt_d) : '0;
        store_release_d = (state_d == LOAD_LAST);
        // RAM write trails the store read by one cycle so the store output has settled.
        ram_we_d        = store_get_q;
        ram_waddr_d     = store_choose_q[VLEN_LOG2-1:0];
        bf_valid_d      = (state_d == BFLY_REQ);
        bf_req_d        = bf_valid_d ? addr_c : '0;
        stage_d         = s_d;
        busy_d          = (state_d != IDLE);
        fft_done_d      = (state_d == DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            j_q             <= '0;
            s_q             <= '0;
            store_get_q     <= 1'b0;
            store_choose_q  <= '0;
            store_release_q <= 1'b0;
            ram_we_q        <= 1'b0;
            ram_waddr_q     <= '0;
            bf_valid_q      <= 1'b0;
            bf_req_q        <= '0;
            stage_q         <= '0;
            busy_q          <= 1'b0;
            fft_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            j_q             <= j_d;
            s_q             <= s_d;
            store_get_q     <= store_get_d;
            store_choose_q  <= store_choose_d;
            store_release_q <= store_release_d;
            ram_we_q        <= ram_we_d;
            ram_waddr_q     <= ram_waddr_d;
            bf_valid_q      <= bf_valid_d;
            bf_req_q        <= bf_req_d;
            stage_q         <= stage_d;
            busy_q          <= busy_d;
            fft_done_q      <= fft_done_d;
        end
    end

    assign io.store_get     = store_get_q;
    assign io.store_choose  = store_choose_q;
    assign io.store_release = store_release_q;
    assign io.ram_we        = ram_we_q;
    assign io.ram_waddr     = ram_waddr_q;
    assign io.bf_valid      = bf_valid_q;
    assign io.bf_top        = bf_req_q.top;
    assign io.bf_bot        = bf_req_q.bot;
    assign io.bf_tw         = bf_req_q.tw;
    assign io.stage         = stage_q;
    assign io.busy          = busy_q;
    assign io.fft_done      = fft_done_q;

`ifdef DIT_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    // Cycle count from LOAD through DONE, saturating; holds while idle.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (state_d == LOAD) begin
                perf_d = '0;
            end
        end else if (perf_q != '1) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_dit_fft_ctrl.sv
// Directed self-checking bench for dit_fft_ctrl: load, address sweep, backpressure, abort, stray events.
module tb_dit_fft_ctrl;
    import dit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic resp_done = 1'b0;
    logic stray_done = 1'b0;
    logic acc;

    int tab_s   [4] = '{0, 2, 3, 1};
    int tab_j   [4] = '{3, 5, 7, 2};
    int tab_top [4] = '{6, 9, 7, 4};
    int tab_bot [4] = '{7, 13, 15, 6};
    int tab_tw  [4] = '{0, 2, 7, 0};

    dit_fft_ctrl_if ifc ();
    assign ifc.bf_done = resp_done | stray_done;

`ifdef DIT_CTRL_PERF_EN
    logic [15:0] perf_cycles;
    dit_fft_ctrl dut (.clk(clk), .rst_n(rst_n), .io(ifc.master), .perf_cycles(perf_cycles));
`else
    dit_fft_ctrl dut (.clk(clk), .rst_n(rst_n), .io(ifc.master));
`endif

    always #5 clk = ~clk;

    // Butterfly unit model: completes one cycle after each accepted request.
    always @(posedge clk) begin
        acc = ifc.bf_valid && ifc.bf_ready;
        #1 resp_done = acc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " store_get"},     32'(ifc.store_get),     32'd0);
        chk({tag, " store_choose"},  32'(ifc.store_choose),  32'd0);
        chk({tag, " store_release"}, 32'(ifc.store_release), 32'd0);
        chk({tag, " ram_we"},        32'(ifc.ram_we),        32'd0);
        chk({tag, " ram_waddr"},     32'(ifc.ram_waddr),     32'd0);
        chk({tag, " bf_valid"},      32'(ifc.bf_valid),      32'd0);
        chk({tag, " bf_top"},        32'(ifc.bf_top),        32'd0);
        chk({tag, " bf_bot"},        32'(ifc.bf_bot),        32'd0);
        chk({tag, " bf_tw"},         32'(ifc.bf_tw),         32'd0);
        chk({tag, " stage"},         32'(ifc.stage),         32'd0);
        chk({tag, " busy"},          32'(ifc.busy),          32'd0);
        chk({tag, " fft_done"},      32'(ifc.fft_done),      32'd0);
`ifdef DIT_CTRL_PERF_EN
        chk({tag, " perf_cycles"},   32'(perf_cycles),       32'd0);
`endif
    endtask

    // One frame: start at edge 0, then 100 observed cycles. Cycle c lies between edge c-1 and edge c.
    task automatic run_frame(input int stall_k, input int stall_len, input int stray_k,
                             input int abort_cyc, input int exp_done);
        int k = 0;
        int stall_left = stall_len;
        int get_n = 0;
        int we_n = 0;
        int rel_n = 0;
        int done_n = 0;
        int done_cyc = -1;
        bit stray_used = 1'b0;
        int s, j, half, idx, top, bot, tw;

        ifc.start      = 1'b1;
        ifc.store_full = 1'b1;
        ifc.bf_ready   = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            stray_done = 1'b0;
            if (c == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                return;
            end
            if (c == 1)  ifc.start = 1'b0;
            if (c == 5)  ifc.store_full = 1'b0;
            if (c == 20) ifc.store_full = 1'b1;
            if (c == 40) ifc.start = 1'b1;
            if (c == 41) ifc.start = 1'b0;

            chk("store_get window", 32'(ifc.store_get), 32'(c >= 1 && c <= 16));
            if (ifc.store_get) begin
                chk("store_choose", 32'(ifc.store_choose), 32'(get_n));
                get_n++;
            end
            chk("ram_we window", 32'(ifc.ram_we), 32'(c >= 2 && c <= 17));
            if (ifc.ram_we) begin
                chk("ram_waddr", 32'(ifc.ram_waddr), 32'(we_n));
                we_n++;
            end
            if (ifc.store_release) begin
                rel_n++;
                chk("store_release cycle", 32'(c), 32'd17);
            end

            ifc.bf_ready = 1'b1;
            if (ifc.bf_valid) begin
                s    = k / 8;
                j    = k % 8;
                half = 2 ** s;
                idx  = j % half;
                top  = (j / half) * 2 * half + idx;
                bot  = top + half;
                tw   = idx * (8 / half);
                chk("bf_top", 32'(ifc.bf_top), 32'(top));
                chk("bf_bot", 32'(ifc.bf_bot), 32'(bot));
                chk("bf_tw",  32'(ifc.bf_tw),  32'(tw));
                chk("stage",  32'(ifc.stage),  32'(s));
                for (int t = 0; t < 4; t++) begin
                    if (tab_s[t] == s && tab_j[t] == j) begin
                        chk("triple top", 32'(ifc.bf_top), 32'(tab_top[t]));
                        chk("triple bot", 32'(ifc.bf_bot), 32'(tab_bot[t]));
                        chk("triple tw",  32'(ifc.bf_tw),  32'(tab_tw[t]));
                    end
                end
                if (k == stall_k && stall_left > 0) begin
                    ifc.bf_ready = 1'b0;
                    stall_left--;
                end else if (k == stray_k && !stray_used) begin
                    ifc.bf_ready = 1'b0;
                    stray_done   = 1'b1;
                    stray_used   = 1'b1;
                end
                if (ifc.bf_ready) k++;
            end

            if (ifc.fft_done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        chk("fft_done cycle", 32'(done_cyc), 32'(exp_done));
        chk("fft_done count", 32'(done_n), 32'd1);
        chk("butterflies", 32'(k), 32'd32);
        chk("store_get count", 32'(get_n), 32'd16);
        chk("ram_we count", 32'(we_n), 32'd16);
        chk("store_release count", 32'(rel_n), 32'd1);
        chk("busy after frame", 32'(ifc.busy), 32'd0);
`ifdef DIT_CTRL_PERF_EN
        chk("perf_cycles", 32'(perf_cycles), 32'(exp_done));
`endif
    endtask

    initial begin
        ifc.start      = 1'b0;
        ifc.store_full = 1'b0;
        ifc.bf_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // start without a full store is dropped and not remembered
        ifc.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no-full busy", 32'(ifc.busy), 32'd0);
            chk("no-full store_get", 32'(ifc.store_get), 32'd0);
        end
        ifc.start      = 1'b0;
        ifc.store_full = 1'b1;
        repeat (3) @(negedge clk);
        chk("start not remembered", 32'(ifc.busy), 32'd0);

        run_frame(-1, 0, -1, 0, 82);
        run_frame(10, 5, -1, 0, 87);

        run_frame(-1, 0, -1, 55, 0);
        @(negedge clk);
        check_zero("held reset");
        rst_n = 1'b1;
        ifc.store_full = 1'b1;
        @(negedge clk);
        chk("idle after abort", 32'(ifc.busy), 32'd0);
        chk("no done after abort", 32'(ifc.fft_done), 32'd0);

        run_frame(-1, 0, -1, 0, 82);
        run_frame(-1, 0, 20, 0, 83);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
